// File: rtl/uart_inst_feeder.sv
// rtl/uart_inst_feeder.sv - buffers UART RX instruction bytes and issues them to the sequencer
module uart_inst_feeder #(
  parameter int DEPTH   = 8,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 1 << 20
) (
  input  logic                       clk,
  input  logic                       arst_i,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_rx_valid,
  input  logic                       i_enable,
  input  logic                       i_seq_tx_valid,
  input  logic                       i_tx_busy,
  input  logic                       i_clr_err,
  output logic [7:0]                 o_inst,
  output logic                       o_inst_valid,
  output logic                       o_send_inst,
  output logic [$clog2(DEPTH):0]     o_fifo_count,
  output logic                       o_overflow,
  output logic                       o_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP) + 1;
  localparam int TW = 21;

  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_WAIT_TXV,
    S_WAIT_BUSY
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [GW-1:0]   gap_cnt;
  logic [TW-1:0]   tcnt;

  logic [7:0]      head;
  logic            is_print;
  logic            pop, push, drop;
  logic            gap_load, tcnt_clr, to_set;

  assign head         = mem[rd_ptr];
  assign is_print     = (head[7:6] == 2'b11);
  // A full FIFO still accepts a byte when the FSM frees a slot in the same cycle.
  assign push         = i_rx_valid && ((count != FULL) || pop);
  assign drop         = i_rx_valid && (count == FULL) && !pop;
  assign o_fifo_count = count;

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= i_rx_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    gap_load  = 1'b0;
    tcnt_clr  = 1'b0;
    to_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_enable && (count != '0)) begin
          pop = 1'b1;
          if (is_print) begin
            state_nxt = S_WAIT_TXV;
            tcnt_clr  = 1'b1;
          end else begin
            state_nxt = S_GAP;
            gap_load  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_nxt = S_IDLE;
      end
      S_WAIT_TXV: begin
        if (i_seq_tx_valid) begin
          state_nxt = S_WAIT_BUSY;
          tcnt_clr  = 1'b1;
        end else if (tcnt == TO_LAST) begin
          state_nxt = S_GAP;
          gap_load  = 1'b1;
          to_set    = 1'b1;
        end
      end
      S_WAIT_BUSY: begin
        // tcnt==0 is the settle cycle: busy may not have risen yet.
        if ((tcnt != '0) && !i_tx_busy) begin
          state_nxt = S_GAP;
          gap_load  = 1'b1;
        end else if (tcnt == TO_LAST) begin
          state_nxt = S_GAP;
          gap_load  = 1'b1;
          to_set    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      gap_cnt <= '0;
      tcnt    <= '0;
    end else begin
      if (gap_load)                          gap_cnt <= GAP_LOAD;
      else if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);

      if (tcnt_clr)                                        tcnt <= '0;
      else if (state == S_WAIT_TXV || state == S_WAIT_BUSY) tcnt <= tcnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      o_inst       <= '0;
      o_inst_valid <= 1'b0;
      o_send_inst  <= 1'b0;
      o_overflow   <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      if (pop) o_inst <= head;
      o_inst_valid <= pop;
      o_send_inst  <= pop && is_print;
      // Set beats clear when both happen in one cycle.
      if (drop)           o_overflow <= 1'b1;
      else if (i_clr_err) o_overflow <= 1'b0;
      if (to_set)         o_timeout  <= 1'b1;
      else if (i_clr_err) o_timeout  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_inst_feeder.sv
// tb/tb_uart_inst_feeder.sv - scoreboard bench for uart_inst_feeder
module tb_uart_inst_feeder;

  logic       clk = 1'b0;
  logic       arst_i;
  logic [7:0] i_rx_data;
  logic       i_rx_valid, i_enable, i_seq_tx_valid, i_tx_busy, i_clr_err;
  logic [7:0] o_inst;
  logic       o_inst_valid, o_send_inst, o_overflow, o_timeout;
  logic [3:0] o_fifo_count;

  uart_inst_feeder #(.DEPTH(8), .GAP(4), .TIMEOUT(64)) dut (
    .clk(clk), .arst_i(arst_i), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_enable(i_enable), .i_seq_tx_valid(i_seq_tx_valid), .i_tx_busy(i_tx_busy),
    .i_clr_err(i_clr_err), .o_inst(o_inst), .o_inst_valid(o_inst_valid),
    .o_send_inst(o_send_inst), .o_fifo_count(o_fifo_count),
    .o_overflow(o_overflow), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] inst;
    logic       send;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [7:0] last_inst = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  task automatic expect_issue(input logic [7:0] d, input logic s, input int c);
    exp_t e;
    e.inst = d; e.send = s; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic push(input logic [7:0] d);
    i_rx_valid = 1'b1;
    i_rx_data  = d;
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && sb.size() > 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    i_clr_err = 1'b1;
    @(negedge clk);
    i_clr_err = 1'b0;
    @(negedge clk);
  endtask

  // Issue monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!arst_i) begin
      if (o_inst_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_issue", 32'(o_inst), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("inst", 32'(o_inst), 32'(e.inst));
          check("send_inst", 32'(o_send_inst), 32'(e.send));
          if (e.cyc >= 0) check("issue_cycle", 32'(cyc), 32'(e.cyc));
        end
        last_inst = o_inst;
      end else begin
        if (o_send_inst) check("send_without_valid", 32'(o_send_inst), 32'd0);
        if (o_inst !== last_inst) check("inst_hold", 32'(o_inst), 32'(last_inst));
      end
    end else begin
      last_inst = 8'h00;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, c, r;
    arst_i = 1'b1; i_rx_data = '0; i_rx_valid = 0; i_enable = 1;
    i_seq_tx_valid = 0; i_tx_busy = 0; i_clr_err = 0;
    repeat (3) @(negedge clk);
    check("rst_inst", 32'(o_inst), 32'd0);
    check("rst_valid", 32'(o_inst_valid), 32'd0);
    check("rst_count", 32'(o_fifo_count), 32'd0);
    check("rst_flags", 32'({o_overflow, o_timeout, o_send_inst}), 32'd0);
    arst_i = 1'b0;
    @(negedge clk);

    // Three non-print bytes back to back
    k = cyc;
    expect_issue(8'h01, 0, k + 2);  push(8'h01);
    expect_issue(8'h12, 0, k + 7);  push(8'h12);
    expect_issue(8'h23, 0, k + 12); push(8'h23);
    wait_drain(40);
    repeat (2) @(negedge clk);
    check("t1_count", 32'(o_fifo_count), 32'd0);

    // Fill with enable low, ninth byte overflows
    i_enable = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expect_issue(8'(i), 0, -1);
      push(8'(i));
    end
    check("t2_count_full", 32'(o_fifo_count), 32'd8);
    check("t2_overflow", 32'(o_overflow), 32'd1);
    i_enable = 1'b1;
    wait_drain(80);
    check("t2_overflow_sticky", 32'(o_overflow), 32'd1);
    pulse_clr();
    check("t2_overflow_clr", 32'(o_overflow), 32'd0);
    repeat (6) @(negedge clk);

    // Print then non-print, print handshake completes normally
    k = cyc;
    c = k + 2;
    expect_issue(8'hC0, 1, c);      push(8'hC0);
    expect_issue(8'h05, 0, c + 67); push(8'h05);
    wait_until(c + 10);
    i_seq_tx_valid = 1'b1;
    @(negedge clk);
    i_seq_tx_valid = 1'b0;
    i_tx_busy = 1'b1;
    wait_until(c + 61);
    i_tx_busy = 1'b0;
    wait_drain(40);
    check("t3_timeout", 32'(o_timeout), 32'd0);
    repeat (6) @(negedge clk);

    // Print with no sequencer handshake times out
    k = cyc;
    c = k + 2;
    expect_issue(8'hC1, 1, c);      push(8'hC1);
    expect_issue(8'h07, 0, c + 69); push(8'h07);
    wait_until(c + 63);
    check("t4_timeout_early", 32'(o_timeout), 32'd0);
    @(negedge clk);
    check("t4_timeout_set", 32'(o_timeout), 32'd1);
    wait_drain(40);
    pulse_clr();
    check("t4_timeout_clr", 32'(o_timeout), 32'd0);

    // Full FIFO with simultaneous push and pop, across pointer wrap
    i_enable = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      expect_issue(8'h10 + 8'(i), 0, -1);
      push(8'h10 + 8'(i));
    end
    check("t5_full", 32'(o_fifo_count), 32'd8);
    i_enable = 1'b1;
    expect_issue(8'h18, 0, -1);
    push(8'h18);
    check("t5_count_held", 32'(o_fifo_count), 32'd8);
    check("t5_no_overflow", 32'(o_overflow), 32'd0);
    wait_drain(80);
    repeat (6) @(negedge clk);

    // Reset in the middle of a print wait with bytes queued
    k = cyc;
    expect_issue(8'hC2, 1, k + 2);
    push(8'hC2);
    push(8'h40); push(8'h41); push(8'h42); push(8'h43);
    i_seq_tx_valid = 1'b1;
    @(negedge clk);
    i_seq_tx_valid = 1'b0;
    i_tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_queued", 32'(o_fifo_count), 32'd4);
    arst_i = 1'b1;
    #1;
    check("t6_rst_count", 32'(o_fifo_count), 32'd0);
    check("t6_rst_outs", 32'({o_inst, o_inst_valid, o_send_inst, o_overflow, o_timeout}), 32'd0);
    @(negedge clk);
    arst_i = 1'b0;
    i_tx_busy = 1'b0;
    @(negedge clk);
    r = cyc;
    expect_issue(8'h33, 0, r + 2);
    push(8'h33);
    wait_drain(20);
    repeat (8) @(negedge clk);
    check("final_count", 32'(o_fifo_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
